// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV64I multicycle controller.
// State values are fixed so the state_o debug port is stable across revisions.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    RESET   = 5'd0,
    FETCH   = 5'd1,
    DECODE  = 5'd2,
    EXEC_I  = 5'd3,
    EXEC_R  = 5'd4,
    WB_ALU  = 5'd5,
    ADDR_LD = 5'd6,
    ADDR_SD = 5'd7,
    MEM_RD  = 5'd8,
    MEM_WR  = 5'd9,
    MEM_WB  = 5'd10,
    BRANCH  = 5'd11,
    LUI     = 5'd12,
    JAL     = 5'd13,
    ERROR   = 5'd31
  } state_t;

  localparam logic [2:0] ALU_LOAD = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic isMemState(state_t s);
    return (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Data-memory request/ready handshake between the controller and the memory.
interface mc_control_unit_if;
  logic dmem_read;
  logic dmem_write;
  logic dmem_ready;

  modport master (output dmem_read, output dmem_write, input dmem_ready);
  modport slave  (input dmem_read, input dmem_write, output dmem_ready);
endinterface

// File: rtl/mc_decode.sv
// Maps the IR opcode/funct fields to the state that follows DECODE.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output state_t     nextState
);

  // instruction class decode; anything unsupported is trapped
  always_comb begin
    nextState = ERROR;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD) nextState = EXEC_I;
        else                  nextState = ERROR;
      end
      OP_REG: begin
        if ((funct3 == F3_ADD) && ((funct7 == F7_BASE) || (funct7 == F7_ALT))) nextState = EXEC_R;
        else                                                                   nextState = ERROR;
      end
      OP_LOAD: begin
        if (funct3 == F3_DW) nextState = ADDR_LD;
        else                 nextState = ERROR;
      end
      OP_STORE: begin
        if (funct3 == F3_DW) nextState = ADDR_SD;
        else                 nextState = ERROR;
      end
      OP_BRANCH: begin
        if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) nextState = BRANCH;
        else                                           nextState = ERROR;
      end
      OP_LUI:  nextState = LUI;
      OP_JAL:  nextState = JAL;
      default: nextState = ERROR;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the RV64I datapath: Moore decode of the state,
// with a bounded wait on data-memory ready and a sticky error state.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  mc_control_unit_if.master  dmem,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               ir_write,
  output logic               imem_read,
  output logic               a_write,
  output logic               b_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               alu_out_write,
  output logic [2:0]         imm_sel,
  output logic               mdr_write,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               branch_ne,
  output logic               error,
  output logic [4:0]         state_o
);

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_t          state_r;
  state_t          nextState_s;
  state_t          decodeNext_s;
  logic [TO_W-1:0] waitCnt_r;
  logic            inMem_s;
  logic            timedOut_s;
  logic            unusedBits_s;

  // alu_zero is combined with branch_ne inside the datapath, not here
  assign unusedBits_s = ^{instr[24:15], instr[11:7], alu_zero};

  assign inMem_s    = isMemState(state_r);
  assign timedOut_s = (waitCnt_r == TIMEOUT_C);
  assign state_o    = state_r;

  mc_decode u_decode (
    .opcode    (instr[6:0]),
    .funct3    (instr[14:12]),
    .funct7    (instr[31:25]),
    .nextState (decodeNext_s)
  );

  // state register and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= RESET;
      waitCnt_r <= '0;
    end else begin
      state_r <= nextState_s;
      if (inMem_s && !dmem.dmem_ready && !timedOut_s) waitCnt_r <= waitCnt_r + TO_W'(1'b1);
      else                                            waitCnt_r <= '0;
    end
  end

  // next-state logic; ready takes priority over the timeout
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      RESET:           nextState_s = FETCH;
      FETCH:           nextState_s = DECODE;
      DECODE:          nextState_s = decodeNext_s;
      EXEC_I, EXEC_R:  nextState_s = WB_ALU;
      ADDR_LD:         nextState_s = MEM_RD;
      ADDR_SD:         nextState_s = MEM_WR;
      MEM_RD: begin
        if (dmem.dmem_ready) nextState_s = MEM_WB;
        else if (timedOut_s) nextState_s = ERROR;
        else                 nextState_s = MEM_RD;
      end
      MEM_WR: begin
        if (dmem.dmem_ready) nextState_s = FETCH;
        else if (timedOut_s) nextState_s = ERROR;
        else                 nextState_s = MEM_WR;
      end
      WB_ALU, MEM_WB, BRANCH, LUI, JAL: nextState_s = FETCH;
      ERROR:           nextState_s = ERROR;
      default:         nextState_s = ERROR;
    endcase
  end

  // Moore output decode
  always_comb begin
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_source       = 2'd0;
    ir_write        = 1'b0;
    imem_read       = 1'b0;
    a_write         = 1'b0;
    b_write         = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'd0;
    alu_op          = ALU_LOAD;
    alu_out_write   = 1'b0;
    imm_sel         = IMM_I;
    dmem.dmem_read  = 1'b0;
    dmem.dmem_write = 1'b0;
    mdr_write       = 1'b0;
    reg_write       = 1'b0;
    wb_sel          = 2'd0;
    branch_ne       = 1'b0;
    error           = 1'b0;
    case (state_r)
      FETCH: begin
        imem_read = 1'b1; ir_write = 1'b1; pc_write = 1'b1;
        alu_src_b = 2'd1; alu_op = ALU_ADD;
      end
      DECODE: begin
        a_write = 1'b1; b_write = 1'b1; alu_out_write = 1'b1;
        alu_src_b = 2'd3; imm_sel = IMM_SB; alu_op = ALU_ADD;
      end
      EXEC_I: begin
        alu_src_a = 1'b1; alu_src_b = 2'd2; imm_sel = IMM_I;
        alu_op = ALU_ADD; alu_out_write = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1; alu_out_write = 1'b1;
        if (instr[30]) alu_op = ALU_SUB;
        else           alu_op = ALU_ADD;
      end
      WB_ALU: reg_write = 1'b1;
      ADDR_LD, ADDR_SD: begin
        alu_src_a = 1'b1; alu_src_b = 2'd2; alu_out_write = 1'b1;
        if (state_r == ADDR_SD) imm_sel = IMM_S;
        else                    imm_sel = IMM_I;
      end
      MEM_RD: begin
        dmem.dmem_read = 1'b1;
        mdr_write      = dmem.dmem_ready;
      end
      MEM_WR: dmem.dmem_write = 1'b1;
      MEM_WB: begin
        reg_write = 1'b1; wb_sel = 2'd1;
      end
      BRANCH: begin
        alu_src_a = 1'b1; alu_op = ALU_SUB; pc_write_cond = 1'b1;
        pc_source = 2'd1; branch_ne = instr[12];
      end
      LUI: begin
        imm_sel = IMM_U; reg_write = 1'b1; wb_sel = 2'd3;
      end
      // datapath feeds imm-4 here because the PC is already incremented
      JAL: begin
        reg_write = 1'b1; wb_sel = 2'd2; alu_src_b = 2'd2; imm_sel = IMM_UJ;
        alu_op = ALU_ADD; pc_write = 1'b1;
      end
      ERROR:   error = 1'b1;
      default: error = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Cycle-table bench for mc_control_unit: each row drives one cycle and checks
// the state and the full output bundle observed during that cycle.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        pc_write, pc_write_cond, ir_write, imem_read, a_write, b_write;
  logic        alu_src_a, alu_out_write, mdr_write, reg_write, branch_ne, error;
  logic [1:0]  pc_source, alu_src_b, wb_sel;
  logic [2:0]  alu_op, imm_sel;
  logic [4:0]  state_o;
  logic [26:0] actOut;

  always #5 clk = ~clk;

  mc_control_unit_if dmemIf();

  mc_control_unit #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .alu_zero      (alu_zero),
    .dmem          (dmemIf),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .imem_read     (imem_read),
    .a_write       (a_write),
    .b_write       (b_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .alu_out_write (alu_out_write),
    .imm_sel       (imm_sel),
    .mdr_write     (mdr_write),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .branch_ne     (branch_ne),
    .error         (error),
    .state_o       (state_o)
  );

  assign actOut = {pc_write, pc_write_cond, pc_source, ir_write, imem_read, a_write, b_write,
                   alu_src_a, alu_src_b, alu_op, alu_out_write, imm_sel, dmemIf.dmem_read,
                   dmemIf.dmem_write, mdr_write, reg_write, wb_sel, branch_ne, error};

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        rdy;
    logic        zero;
    logic [4:0]  st;
    logic [26:0] o;
  } vec_t;

  vec_t tbl[$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_ADD  = 32'h00208133;
  localparam logic [31:0] I_LD   = 32'h0080B103;
  localparam logic [31:0] I_SD   = 32'h0020B023;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LUI  = 32'h000120B7;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_BLT  = 32'h0020C463;

  logic [26:0] oZero, oFetch, oDecode, oExecI, oExecRsub, oExecRadd, oWbAlu, oAddrLd, oAddrSd;
  logic [26:0] oMemRd, oMemRdRdy, oMemWr, oMemWb, oBrNe, oBrEq, oLui, oJal, oErr;

  function automatic logic [26:0] outs(
    logic pcw, logic pcwc, logic [1:0] pcs, logic irw, logic imr, logic aw, logic bw,
    logic asa, logic [1:0] asb, logic [2:0] aop, logic aow, logic [2:0] isel,
    logic dr, logic dw, logic mdr, logic rw, logic [1:0] wbs, logic bne, logic err);
    return {pcw, pcwc, pcs, irw, imr, aw, bw, asa, asb, aop, aow, isel, dr, dw, mdr, rw, wbs, bne, err};
  endfunction

  function automatic vec_t mkv(logic rst, logic [31:0] ins, logic rdy, logic zero,
                               logic [4:0] st, logic [26:0] o);
    vec_t v;
    v.rst = rst; v.ins = ins; v.rdy = rdy; v.zero = zero; v.st = st; v.o = o;
    return v;
  endfunction

  function automatic void addRow(logic rst, logic [31:0] ins, logic rdy, logic [4:0] st, logic [26:0] o);
    tbl.push_back(mkv(rst, ins, rdy, 1'b0, st, o));
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic runRow(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; instr = v.ins; dmemIf.dmem_ready = v.rdy; alu_zero = v.zero;
    #1;
    check({tag, " state"}, 32'(state_o), 32'(v.st));
    check({tag, " outs"}, 32'(actOut), 32'(v.o));
  endtask

  initial begin
    oZero     = '0;
    oFetch    = outs(1'b1,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd1,3'd1,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oDecode   = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd3,3'd1,1'b1,3'd2,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oExecI    = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd1,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oExecRsub = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd2,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oExecRadd = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd1,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oWbAlu    = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0);
    oAddrLd   = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd0,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oAddrSd   = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd0,1'b1,3'd1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oMemRd    = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oMemRdRdy = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0);
    oMemWr    = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0);
    oMemWb    = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b0);
    oBrNe     = outs(1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd2,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0);
    oBrEq     = outs(1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd2,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0);
    oLui      = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd3,1'b0,1'b0,1'b0,1'b1,2'd3,1'b0,1'b0);
    oJal      = outs(1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,3'd1,1'b0,3'd4,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,1'b0);
    oErr      = outs(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1);

    // addi, sub, add
    addRow(1'b0, I_ADDI, 1'b0, FETCH,  oFetch);
    addRow(1'b0, I_ADDI, 1'b0, DECODE, oDecode);
    addRow(1'b0, I_ADDI, 1'b0, EXEC_I, oExecI);
    addRow(1'b0, I_ADDI, 1'b0, WB_ALU, oWbAlu);
    addRow(1'b0, I_SUB,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_SUB,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_SUB,  1'b0, EXEC_R, oExecRsub);
    addRow(1'b0, I_SUB,  1'b0, WB_ALU, oWbAlu);
    addRow(1'b0, I_ADD,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_ADD,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_ADD,  1'b0, EXEC_R, oExecRadd);
    addRow(1'b0, I_ADD,  1'b0, WB_ALU, oWbAlu);
    // ld with 3 wait cycles; ready outside memory states is ignored
    addRow(1'b0, I_LD,   1'b1, FETCH,  oFetch);
    addRow(1'b0, I_LD,   1'b1, DECODE, oDecode);
    addRow(1'b0, I_LD,   1'b1, ADDR_LD, oAddrLd);
    addRow(1'b0, I_LD,   1'b0, MEM_RD, oMemRd);
    addRow(1'b0, I_LD,   1'b0, MEM_RD, oMemRd);
    addRow(1'b0, I_LD,   1'b0, MEM_RD, oMemRd);
    addRow(1'b0, I_LD,   1'b1, MEM_RD, oMemRdRdy);
    addRow(1'b0, I_LD,   1'b0, MEM_WB, oMemWb);
    // sd with one wait cycle
    addRow(1'b0, I_SD,   1'b0, FETCH,  oFetch);
    addRow(1'b0, I_SD,   1'b0, DECODE, oDecode);
    addRow(1'b0, I_SD,   1'b0, ADDR_SD, oAddrSd);
    addRow(1'b0, I_SD,   1'b0, MEM_WR, oMemWr);
    addRow(1'b0, I_SD,   1'b1, MEM_WR, oMemWr);
    // bne, beq, lui, jal
    addRow(1'b0, I_BNE,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_BNE,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_BNE,  1'b0, BRANCH, oBrNe);
    addRow(1'b0, I_BEQ,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_BEQ,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_BEQ,  1'b0, BRANCH, oBrEq);
    addRow(1'b0, I_LUI,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_LUI,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_LUI,  1'b0, LUI,    oLui);
    addRow(1'b0, I_JAL,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_JAL,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_JAL,  1'b0, JAL,    oJal);
    // illegal opcode, then unsupported branch funct3; both trap until reset
    addRow(1'b0, I_BAD,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_BAD,  1'b0, DECODE, oDecode);
    addRow(1'b0, I_BAD,  1'b1, ERROR,  oErr);
    addRow(1'b1, I_BAD,  1'b0, ERROR,  oErr);
    addRow(1'b0, I_BLT,  1'b0, RESET,  oZero);
    addRow(1'b0, I_BLT,  1'b0, FETCH,  oFetch);
    addRow(1'b0, I_BLT,  1'b0, DECODE, oDecode);
    addRow(1'b1, I_BLT,  1'b0, ERROR,  oErr);
    addRow(1'b0, I_BLT,  1'b0, RESET,  oZero);

    reset = 1'b1; instr = 32'h0; alu_zero = 1'b0; dmemIf.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    runRow(mkv(1'b0, 32'h0, 1'b0, 1'b0, RESET, oZero), "reset");

    for (int i = 0; i < tbl.size(); i++) runRow(tbl[i], $sformatf("row%0d", i));

    // sd never ready: 17 MEM_WR cycles, then sticky ERROR until reset
    runRow(mkv(1'b0, I_SD, 1'b0, 1'b0, FETCH,   oFetch),  "to fetch");
    runRow(mkv(1'b0, I_SD, 1'b0, 1'b0, DECODE,  oDecode), "to decode");
    runRow(mkv(1'b0, I_SD, 1'b0, 1'b0, ADDR_SD, oAddrSd), "to addr");
    for (int k = 0; k < 17; k++)
      runRow(mkv(1'b0, I_SD, 1'b0, 1'b0, MEM_WR, oMemWr), $sformatf("to wr%0d", k));
    runRow(mkv(1'b0, I_SD, 1'b1, 1'b0, ERROR, oErr), "to err0");
    runRow(mkv(1'b0, I_SD, 1'b0, 1'b0, ERROR, oErr), "to err1");
    runRow(mkv(1'b1, I_SD, 1'b0, 1'b0, ERROR, oErr), "to err2");
    runRow(mkv(1'b0, I_SD, 1'b0, 1'b0, RESET, oZero), "to reset");

    // reset in the middle of a load
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, FETCH,   oFetch),  "rm fetch");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, DECODE,  oDecode), "rm decode");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, ADDR_LD, oAddrLd), "rm addr");
    runRow(mkv(1'b1, I_LD, 1'b0, 1'b0, MEM_RD,  oMemRd),  "rm rd");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, RESET,   oZero),   "rm reset");

    // ready arrives exactly when the counter equals TIMEOUT: completion wins
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, FETCH,   oFetch),  "tb fetch");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, DECODE,  oDecode), "tb decode");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, ADDR_LD, oAddrLd), "tb addr");
    for (int k = 0; k < 16; k++)
      runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, MEM_RD, oMemRd), $sformatf("tb rd%0d", k));
    runRow(mkv(1'b0, I_LD, 1'b1, 1'b0, MEM_RD, oMemRdRdy), "tb rdlast");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, MEM_WB, oMemWb),    "tb wb");
    runRow(mkv(1'b0, I_LD, 1'b0, 1'b0, FETCH,  oFetch),    "tb fetch2");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multicycle control FSM for the RV64I datapath. Decodes the instruction register and sequences PC, IR, register file, A/B, ALU, ALUOut, MDR and data memory through fetch/decode/execute/memory/writeback. Successor to the fixed-sequence controller, with these additions:
- Data-memory ready/timeout handshake.
- Branch, LUI and JAL support.
- An explicit sticky error state.

## Interface
Parameters:
- TIMEOUT, default 16: maximum cycles spent waiting for `dmem_ready` before entering ERROR; legal range 1–255.
- TO_W, default $clog2(TIMEOUT+1): width of the wait counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- instr, in, 32: current IR contents.
- dmem_ready, in, 1: data memory has completed the pending read or write.
- alu_zero, in, 1: ALU zero flag, used for branches.
- pc_write, out, 1: unconditional PC load.
- pc_write_cond, out, 1: PC load qualified by the branch condition.
- pc_source, out, 2: PC mux select; 0 = ALU result, 1 = ALUOut.
- ir_write, out, 1: load IR.
- imem_read, out, 1: instruction memory read.
- a_write, out, 1: load register A.
- b_write, out, 1: load register B.
- alu_src_a, out, 1: ALU operand A select; 0 = PC, 1 = A.
- alu_src_b, out, 2: ALU operand B select; 0 = B, 1 = const 4, 2 = imm, 3 = imm.
- alu_op, out, 3: ALU operation (encoding from package).
- alu_out_write, out, 1: load ALUOut.
- imm_sel, out, 3: immediate format (I/S/SB/U/UJ).
- dmem_read, out, 1: data memory read request.
- dmem_write, out, 1: data memory write request.
- mdr_write, out, 1: load MDR.
- reg_write, out, 1: register file write.
- wb_sel, out, 2: writeback mux; 0 = ALUOut, 1 = MDR, 2 = PC, 3 = imm.
- branch_ne, out, 1: invert `alu_zero` in the branch condition.
- error, out, 1: sticky error flag.
- state_o, out, 5: current state, for debug.

## Operation
- Outputs are a pure Moore decode of `state`. Every output not listed for a state is 0.
- **RESET**: all outputs 0. Unconditionally → FETCH.
- **FETCH**:
  - Outputs: imem_read, ir_write, pc_write, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - → DECODE.
- **DECODE**:
  - Outputs: a_write, b_write, alu_out_write, alu_src_a=0, alu_src_b=3, imm_sel=SB, alu_op=ADD. This precomputes the branch target.
  - Next state by opcode/funct:
    - 0010011/000 → EXEC_I.
    - 0110011, funct7 0000000 or 0100000, funct3 000 → EXEC_R.
    - 0000011/011 → ADDR_LD.
    - 0100011/011 → ADDR_SD.
    - 1100011 with funct3 000 or 001 → BRANCH.
    - 0110111 → LUI.
    - 1101111 → JAL.
    - Anything else → ERROR.
- **EXEC_I**: alu_src_a=1, alu_src_b=2, imm_sel=I, alu_op=ADD, alu_out_write. → WB_ALU.
- **EXEC_R**: alu_src_a=1, alu_src_b=0, alu_out_write; alu_op = SUB when funct7[5]=1, else ADD. → WB_ALU.
- **WB_ALU**: reg_write, wb_sel=0. → FETCH.
- **ADDR_LD / ADDR_SD**: alu_src_a=1, alu_src_b=2, alu_out_write; imm_sel = I for ADDR_LD, S for ADDR_SD. → MEM_RD / MEM_WR.
- **MEM_RD**:
  - Outputs: dmem_read, plus mdr_write while dmem_ready=1.
  - Leaves when dmem_ready=1 → MEM_WB.
- **MEM_WR**: dmem_write held until dmem_ready=1 → FETCH.
- **MEM_WB**: reg_write, wb_sel=1. → FETCH.
- **BRANCH**:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond, pc_source=1, branch_ne=funct3[0].
  - → FETCH.
- **LUI**: imm_sel=U, reg_write, wb_sel=3. → FETCH.
- **JAL**:
  - Outputs: reg_write, wb_sel=2 (link = PC already incremented), alu_src_a=0, alu_src_b=2, imm_sel=UJ, alu_op=ADD, pc_write, pc_source=0.
  - JAL's PC-relative base is the incremented PC; the datapath compensates by supplying imm−4.
  - → FETCH.
- **ERROR**: error=1, all other outputs 0. Held until reset.
- **Wait counter**:
  - Cleared on entry to MEM_RD or MEM_WR.
  - Increments each cycle in those states while dmem_ready=0.
  - When it reaches TIMEOUT with dmem_ready still 0 → ERROR. The request strobe drops in that same edge.
  - dmem_ready=1 in the same cycle as count==TIMEOUT: the completion wins.

## Timing
- Reset: on a rising edge with reset=1, state=RESET and counter=0. This overrides any state, including mid-access and ERROR.
- Cycle counts, including FETCH:
  - addi/add/sub: 4.
  - lui/jal/branch: 3.
  - ld: 5 + w, where w = cycles with dmem_ready low.
  - sd: 4 + w.
- dmem_read / dmem_write stay asserted continuously from state entry until the edge at which dmem_ready=1 is sampled.
- dmem_ready is ignored outside MEM_RD and MEM_WR.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum, 5 bits, with fixed values RESET=0, FETCH=1, DECODE=2, EXEC_I=3, EXEC_R=4, WB_ALU=5, ADDR_LD=6, ADDR_SD=7, MEM_RD=8, MEM_WR=9, MEM_WB=10, BRANCH=11, LUI=12, JAL=13, ERROR=31.
  - alu_op constants: LOAD=0, ADD=1, SUB=2, AND=3, XOR=4.
  - imm_sel constants: I=0, S=1, SB=2, U=3, UJ=4.
  - opcode localparams.
- One sub-module, `mc_decode`: combinational instr → next-state-after-DECODE.

## Test plan
- reset then addi x1,x0,5 (0x00500093) → states 1,2,3,5,1; reg_write=1 only in WB_ALU; alu_src_b=2 in EXEC_I.
- sub (0x40208133) → EXEC_R with alu_op=2; add (0x00208133) → alu_op=1.
- ld with dmem_ready low for 3 cycles → dmem_read high for 4 cycles, mdr_write only in the ready cycle, MEM_WB next; total 8 cycles.
- sd with dmem_ready never asserted, TIMEOUT=16 → ERROR after 17 MEM_WR cycles; error stays 1 until reset, then state=RESET.
- bne (funct3 001) with alu_zero=0 → pc_write_cond=1, branch_ne=1, pc_source=1 in BRANCH; opcode 0x7F → ERROR directly from DECODE.
- reset asserted during MEM_RD → next edge state=RESET with all outputs 0; dmem_ready=1 at count==TIMEOUT → MEM_WB, not ERROR.
